// File: rtl/rgb_to_luma.sv
// rgb_to_luma: RGB888 to 8-bit luma converter with aligned syncs and active-geometry measurement.
// Latency: fixed 3 cycles from r_i/g_i/b_i/dv_i/hs_i/vs_i to y_o/dv_o/hs_o/vs_o.
// Backpressure: none; a pixel-rate stream that accepts one sample every clock.
//
// Ports:
//   clk, rst_n            pixel clock (rising edge), synchronous active-low reset
//   r_i, g_i, b_i         8-bit colour components, sampled every cycle
//   dv_i, hs_i, vs_i      data valid / horizontal sync / vertical sync (active high)
//   y_o                   luma, rounded, 3 cycles after the matching RGB input
//   dv_o, hs_o, vs_o      input syncs delayed by 3 cycles, aligned with y_o
//   width_o, height_o     active pixels per line / active lines of the last complete frame
//   geom_valid_o          width_o/height_o describe a consistent frame within MAX_WIDTH x MAX_HEIGHT
//
// Build option: define LUMA_BT709_EN for BT.709 weights (54/183/19); default is BT.601 (77/150/29).

module rgb_to_luma #(
    parameter int MAX_WIDTH  = 1600,
    parameter int MAX_HEIGHT = 900
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  r_i,
    input  logic [7:0]  g_i,
    input  logic [7:0]  b_i,
    input  logic        dv_i,
    input  logic        hs_i,
    input  logic        vs_i,
    output logic [7:0]  y_o,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic [10:0] width_o,
    output logic [9:0]  height_o,
    output logic        geom_valid_o
);

    // Weights always sum to 256, so the rounded sum never exceeds 65408.
`ifdef LUMA_BT709_EN
    localparam logic [15:0] C_R = 16'd54;
    localparam logic [15:0] C_G = 16'd183;
    localparam logic [15:0] C_B = 16'd19;
`else
    localparam logic [15:0] C_R = 16'd77;
    localparam logic [15:0] C_G = 16'd150;
    localparam logic [15:0] C_B = 16'd29;
`endif

    localparam logic [10:0] MAX_W     = 11'(MAX_WIDTH);
    localparam logic [9:0]  MAX_H     = 10'(MAX_HEIGHT);
    localparam logic [10:0] PIX_SAT   = 11'h7FF;
    localparam logic [9:0]  LINE_SAT  = 10'h3FF;

    // ------------------------------------------------------------------
    // Luma datapath
    // ------------------------------------------------------------------
    logic [15:0] r_p_r;
    logic [15:0] r_p_g;
    logic [15:0] r_p_b;
    logic [16:0] r_sum;
    logic [7:0]  r_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p_r <= 16'd0;
            r_p_g <= 16'd0;
            r_p_b <= 16'd0;
            r_sum <= 17'd0;
            r_y   <= 8'd0;
        end else begin
            r_p_r <= C_R * {8'd0, r_i};
            r_p_g <= C_G * {8'd0, g_i};
            r_p_b <= C_B * {8'd0, b_i};
            // +128 rounds the >>8 to nearest.
            r_sum <= {1'b0, r_p_r} + {1'b0, r_p_g} + {1'b0, r_p_b} + 17'd128;
            // Bit 16 cannot be set with weights summing to 256; the clamp is a
            // guard in case the weights are ever changed.
            r_y   <= r_sum[16] ? 8'hFF : r_sum[15:8];
        end
    end

    assign y_o = r_y;

    // ------------------------------------------------------------------
    // Sync delay lines, same depth as the luma pipe
    // ------------------------------------------------------------------
    logic [2:0] r_dv_sr;
    logic [2:0] r_hs_sr;
    logic [2:0] r_vs_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dv_sr <= 3'b000;
            r_hs_sr <= 3'b000;
            r_vs_sr <= 3'b000;
        end else begin
            r_dv_sr <= {r_dv_sr[1:0], dv_i};
            r_hs_sr <= {r_hs_sr[1:0], hs_i};
            r_vs_sr <= {r_vs_sr[1:0], vs_i};
        end
    end

    assign dv_o = r_dv_sr[2];
    assign hs_o = r_hs_sr[2];
    assign vs_o = r_vs_sr[2];

    // ------------------------------------------------------------------
    // Geometry measurement
    // ------------------------------------------------------------------
    logic        r_dv_dly;
    logic        r_vs_dly;
    logic [10:0] r_pix_cnt;
    logic [10:0] r_line_w;
    logic [9:0]  r_line_cnt;
    logic        r_mismatch;
    logic        r_armed;
    // Set when a vs edge cut a run short; the rest of that run is ignored
    // until dv falls so the tail is not counted as a line.
    logic        r_skip_run;
    logic [10:0] r_width;
    logic [9:0]  r_height;
    logic        r_geom_valid;

    logic w_vs_rise;
    logic w_dv_fall;
    logic w_geom_ok;

    assign w_vs_rise = vs_i & ~r_vs_dly;
    assign w_dv_fall = r_dv_dly & ~dv_i;

    assign w_geom_ok = !r_mismatch
                       && (r_line_w != 11'd0) && (r_line_w <= MAX_W)
                       && (r_line_cnt != 10'd0) && (r_line_cnt <= MAX_H);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Delay registers start high so a sync already asserted at
            // release does not look like a fresh edge.
            r_dv_dly     <= 1'b1;
            r_vs_dly     <= 1'b1;
            r_pix_cnt    <= 11'd0;
            r_line_w     <= 11'd0;
            r_line_cnt   <= 10'd0;
            r_mismatch   <= 1'b0;
            r_armed      <= 1'b0;
            r_skip_run   <= 1'b0;
            r_width      <= 11'd0;
            r_height     <= 10'd0;
            r_geom_valid <= 1'b0;
        end else begin
            r_dv_dly <= dv_i;
            r_vs_dly <= vs_i;

            if (w_vs_rise) begin
                // Frame boundary has priority over any line event this cycle;
                // a line ending on the same cycle is dropped.
                if (r_armed) begin
                    r_width      <= r_line_w;
                    r_height     <= r_line_cnt;
                    r_geom_valid <= w_geom_ok;
                end
                r_line_cnt <= 10'd0;
                r_line_w   <= 11'd0;
                r_mismatch <= 1'b0;
                r_pix_cnt  <= 11'd0;
                r_armed    <= 1'b1;
                r_skip_run <= dv_i;
            end else if (w_dv_fall) begin
                if (r_skip_run) begin
                    r_skip_run <= 1'b0;
                    r_pix_cnt  <= 11'd0;
                end else begin
                    r_line_w  <= r_pix_cnt;
                    r_pix_cnt <= 11'd0;
                    if (r_line_cnt != LINE_SAT) begin
                        r_line_cnt <= r_line_cnt + 10'd1;
                    end
                    if ((r_line_w != 11'd0) && (r_line_w != r_pix_cnt)) begin
                        r_mismatch <= 1'b1;
                    end
                end
            end else if (dv_i && !r_skip_run) begin
                if (r_pix_cnt != PIX_SAT) begin
                    r_pix_cnt <= r_pix_cnt + 11'd1;
                end
            end
        end
    end

    assign width_o      = r_width;
    assign height_o     = r_height;
    assign geom_valid_o = r_geom_valid;

endmodule

// File: tb/tb_rgb_to_luma.sv
module tb_rgb_to_luma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  r_i, g_i, b_i;
    logic        dv_i, hs_i, vs_i;
    logic [7:0]  y_o;
    logic        dv_o, hs_o, vs_o;
    logic [10:0] width_o;
    logic [9:0]  height_o;
    logic        geom_valid_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_to_luma dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_i          (r_i),
        .g_i          (g_i),
        .b_i          (b_i),
        .dv_i         (dv_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .y_o          (y_o),
        .dv_o         (dv_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .width_o      (width_o),
        .height_o     (height_o),
        .geom_valid_o (geom_valid_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_geom(input string tag, input int w, input int h, input int v);
        chk({tag, ".width"},  {21'd0, width_o},  w);
        chk({tag, ".height"}, {22'd0, height_o}, h);
        chk({tag, ".valid"},  {31'd0, geom_valid_o}, v);
    endtask

    task automatic line(input int w);
        dv_i = 1'b1;
        repeat (w) tick();
        dv_i = 1'b0;
        hs_i = 1'b1;
        repeat (2) tick();
        hs_i = 1'b0;
        repeat (2) tick();
    endtask

    task automatic lines(input int w, input int n);
        for (int i = 0; i < n; i++) line(w);
    endtask

    task automatic vsync();
        vs_i = 1'b1;
        repeat (2) tick();
        vs_i = 1'b0;
        repeat (2) tick();
    endtask

    task automatic colour(input string tag, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input int exp);
        r_i = r; g_i = g; b_i = b;
        repeat (3) tick();
        chk(tag, {24'd0, y_o}, exp);
    endtask

    logic [2:0] hist[$];

    initial begin
        rst_n = 1'b0;
        r_i = 8'hFF; g_i = 8'hFF; b_i = 8'hFF;
        dv_i = 1'b1; hs_i = 1'b0; vs_i = 1'b1;

        // Reset held two cycles with active white pixels and vs high.
        repeat (2) tick();
        chk("rst.y",      {24'd0, y_o}, 0);
        chk("rst.dv",     {31'd0, dv_o}, 0);
        chk("rst.vs",     {31'd0, vs_o}, 0);
        chk_geom("rst", 0, 0, 0);

        rst_n = 1'b1;
        tick();
        chk("pipe.dv1", {31'd0, dv_o}, 0);
        tick();
        chk("pipe.dv2", {31'd0, dv_o}, 0);
        tick();
        chk("pipe.y3",  {24'd0, y_o}, 255);
        chk("pipe.dv3", {31'd0, dv_o}, 1);
        dv_i = 1'b0;
        vs_i = 1'b0;
        repeat (3) tick();

        // Colour vectors: y = (w_r*R + w_g*G + w_b*B + 128) >> 8
`ifdef LUMA_BT709_EN
        colour("col.red",   8'd255, 8'd0,   8'd0,   54);
        colour("col.green", 8'd0,   8'd255, 8'd0,   182);
        colour("col.blue",  8'd0,   8'd0,   8'd255, 19);
`else
        colour("col.red",   8'd255, 8'd0,   8'd0,   77);
        colour("col.green", 8'd0,   8'd255, 8'd0,   149);
        colour("col.blue",  8'd0,   8'd0,   8'd255, 29);
`endif
        colour("col.black", 8'd0,   8'd0,   8'd0,   0);
        colour("col.grey",  8'd128, 8'd128, 8'd128, 128);
        colour("col.white", 8'd255, 8'd255, 8'd255, 255);

        // First vs edge after reset only arms (held-high vs at release did not).
        lines(1600, 4);
        vsync();
        chk_geom("arm", 0, 0, 0);

        lines(1600, 4);
        vsync();
        chk_geom("nom2", 1600, 4, 1);
        lines(1600, 4);
        vsync();
        chk_geom("nom3", 1600, 4, 1);

        // One short line inside a 1600-wide frame.
        line(1600);
        line(1599);
        lines(1600, 2);
        vsync();
        chk_geom("short", 1600, 4, 0);

        lines(1604, 4);
        vsync();
        chk_geom("wide", 1604, 4, 0);

        lines(640, 6);
        vsync();
        chk_geom("vga", 640, 6, 1);

        lines(8, 900);
        vsync();
        chk_geom("h900", 8, 900, 1);
        lines(8, 901);
        vsync();
        chk_geom("h901", 8, 901, 0);

        // vs rises while dv is high mid-line; the tail of that run is discarded.
        lines(8, 2);
        dv_i = 1'b1;
        repeat (3) tick();
        vs_i = 1'b1;
        tick();
        repeat (2) tick();
        dv_i = 1'b0;
        vs_i = 1'b0;
        repeat (2) tick();
        chk_geom("colA.prev", 8, 2, 1);
        lines(8, 4);
        vsync();
        chk_geom("colA", 8, 4, 1);

        // dv falls on the same cycle vs rises: that line is dropped.
        lines(8, 3);
        dv_i = 1'b1;
        repeat (8) tick();
        dv_i = 1'b0;
        vs_i = 1'b1;
        repeat (2) tick();
        vs_i = 1'b0;
        repeat (2) tick();
        chk_geom("colB.prev", 8, 3, 1);
        lines(8, 4);
        vsync();
        chk_geom("colB", 8, 4, 1);

        // Reset mid-frame clears outputs and requires re-arming.
        r_i = 8'd128; g_i = 8'd128; b_i = 8'd128;
        lines(8, 2);
        rst_n = 1'b0;
        tick();
        chk("mrst.y", {24'd0, y_o}, 0);
        chk_geom("mrst", 0, 0, 0);
        rst_n = 1'b1;
        lines(8, 4);
        vsync();
        chk_geom("rearm", 0, 0, 0);
        lines(8, 4);
        vsync();
        chk_geom("relatch", 8, 4, 1);

        // Random sync pattern: outputs equal inputs three cycles earlier.
        for (int n = 0; n < 10000; n++) begin
            dv_i = 1'($urandom);
            hs_i = 1'($urandom);
            vs_i = 1'($urandom);
            tick();
            hist.push_back({dv_i, hs_i, vs_i});
            if (hist.size() > 3) void'(hist.pop_front());
            if (hist.size() == 3) begin
                chk("sync", {29'd0, dv_o, hs_o, vs_o}, {29'd0, hist[0]});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
